// File: rtl/dt_pkg.sv
// Shared types for the sti pixel streamer: scan direction, FSM states and
// the derived ROM word count.
package dt_pkg;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_BWD = 1'b1
  } scan_dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EMIT,
    ST_DONE
  } stream_state_e;

  // Number of packed ROM words making up one image.
  function automatic int unsigned calc_nwords(input int unsigned img_w,
                                              input int unsigned img_h,
                                              input int unsigned word_w);
    return (img_w * img_h) / word_w;
  endfunction

endpackage

// File: rtl/sti_word_shift_reg.sv
// WORD_W-bit load/shift register. Forward scans shift left and present the
// MSB; backward scans shift right and present the LSB. A bit counter flags
// the final bit of the loaded word.
module sti_word_shift_reg
  import dt_pkg::*;
#(
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  scan_dir_e         dir,
  input  logic [WORD_W-1:0] din,
  output logic              bit_out,
  output logic              word_last
);

  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WORD_W-1:0] sr_q;
  logic [CNT_W-1:0]  cnt_q;

  // Load a fresh word or consume one bit in the scan direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      sr_q  <= din;
      cnt_q <= '0;
    end else if (shift) begin
      if (dir == DIR_FWD) sr_q <= {sr_q[WORD_W-2:0], 1'b0};
      else                sr_q <= {1'b0, sr_q[WORD_W-1:1]};
      cnt_q <= word_last ? '0 : cnt_q + CNT_ONE;
    end
  end

  // Current output bit and end-of-word flag.
  always_comb begin
    bit_out   = (dir == DIR_FWD) ? sr_q[WORD_W-1] : sr_q[0];
    word_last = (cnt_q == CNT_LAST);
  end

endmodule

// File: rtl/sti_pixel_streamer.sv
// Streams a packed binary image from the sti ROM one pixel per handshake,
// in forward (index ascending) or backward (index descending) raster order.
module sti_pixel_streamer
  import dt_pkg::*;
#(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned IMG_H  = 128,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned IDX_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  output logic              busy,
  output logic              done,
  output logic              sti_rd,
  output logic [ADDR_W-1:0] sti_addr,
  input  logic [WORD_W-1:0] sti_di,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_bit,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_last
);

  localparam int unsigned NWORDS = calc_nwords(IMG_W, IMG_H, WORD_W);
  localparam int unsigned NPIX   = IMG_W * IMG_H;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NWORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NPIX - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  stream_state_e     state_q, state_nxt;
  scan_dir_e         dir_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  idx_q;

  logic handshake;
  logic word_last;
  logic last_word;
  logic last_pix;
  logic sr_bit;

  sti_word_shift_reg #(
    .WORD_W(WORD_W)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == ST_LOAD),
    .shift    (handshake),
    .dir      (dir_q),
    .din      (sti_di),
    .bit_out  (sr_bit),
    .word_last(word_last)
  );

  // Terminal conditions by compare, so neither counter ever wraps.
  always_comb begin
    handshake = (state_q == ST_EMIT) && pix_ready;
    last_word = (dir_q == DIR_FWD) ? (addr_q == ADDR_LAST) : (addr_q == '0);
    last_pix  = word_last && last_word;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    sti_rd    = 1'b0;
    pix_valid = 1'b0;
    pix_bit   = 1'b0;
    pix_last  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        busy      = 1'b1;
        sti_rd    = 1'b1;
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        busy      = 1'b1;
        state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        busy      = 1'b1;
        pix_valid = 1'b1;
        pix_bit   = sr_bit;
        pix_last  = last_pix;
        if (handshake && word_last) state_nxt = last_word ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Direction latch, ROM address counter and pixel index counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q  <= DIR_FWD;
      addr_q <= '0;
      idx_q  <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        dir_q  <= scan_dir_e'(dir);
        addr_q <= dir ? ADDR_LAST : '0;
        idx_q  <= dir ? IDX_LAST : '0;
      end
    end else if (handshake) begin
      if (!last_pix)
        idx_q <= (dir_q == DIR_FWD) ? idx_q + IDX_ONE : idx_q - IDX_ONE;
      if (word_last && !last_word)
        addr_q <= (dir_q == DIR_FWD) ? addr_q + ADDR_ONE : addr_q - ADDR_ONE;
    end
  end

  assign sti_addr = addr_q;
  assign pix_idx  = idx_q;

endmodule

// File: tb/tb_sti_pixel_streamer.sv
// Self-checking bench for sti_pixel_streamer: default 128x128/16-bit build
// plus a small 16x16/8-bit build, each fed by a negedge-read ROM model.
module tb_sti_pixel_streamer;

  localparam int NPIX   = 128 * 128;
  localparam int NWORDS = NPIX / 16;
  localparam int S_NPIX = 16 * 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  // default instance
  logic        start = 1'b0, dir = 1'b0, pix_ready = 1'b1;
  logic        busy, done, sti_rd, pix_valid, pix_bit, pix_last;
  logic [9:0]  sti_addr;
  logic [15:0] sti_di = '0;
  logic [13:0] pix_idx;

  // small instance
  logic        s_start = 1'b0, s_dir = 1'b0, s_ready = 1'b1;
  logic        s_busy, s_done, s_rd, s_valid, s_bit, s_last;
  logic [4:0]  s_addr;
  logic [7:0]  s_di = '0;
  logic [7:0]  s_idx;

  logic [15:0] rom  [NWORDS];
  logic [7:0]  srom [32];

  int checks = 0;
  int failures = 0;

  // model state for the default instance
  logic        m_dir = 1'b0;
  int          m_n = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] first16 = '0;
  logic        stall_q = 1'b0;
  logic        hold_bit, hold_last;
  int          hold_idx;

  // model state for the small instance
  int s_n = 0, s_rd_cnt = 0, s_last_idx = -1, s_last_cnt = 0;

  always #5 clk = ~clk;

  sti_pixel_streamer dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .busy(busy), .done(done),
    .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_bit(pix_bit), .pix_idx(pix_idx), .pix_last(pix_last)
  );

  sti_pixel_streamer #(
    .WORD_W(8), .IMG_W(16), .IMG_H(16), .ADDR_W(5), .IDX_W(8)
  ) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .dir(s_dir), .busy(s_busy), .done(s_done),
    .sti_rd(s_rd), .sti_addr(s_addr), .sti_di(s_di), .pix_valid(s_valid),
    .pix_ready(s_ready), .pix_bit(s_bit), .pix_idx(s_idx), .pix_last(s_last)
  );

  // ROM models: data latched on negedge while the read strobe is high.
  always @(negedge clk) if (sti_rd) sti_di <= rom[sti_addr];
  always @(negedge clk) if (s_rd)   s_di   <= srom[s_addr];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // pixel p lives in word p/W, bit W-1-(p%W) (MSB holds the lowest index)
  function automatic logic img_bit(input int p);
    logic [15:0] w;
    w = rom[p / 16];
    return w[15 - (p % 16)];
  endfunction

  function automatic logic s_img_bit(input int p);
    logic [7:0] w;
    w = srom[p / 8];
    return w[7 - (p % 8)];
  endfunction

  // Compare process for the default instance.
  always @(negedge clk) begin
    if (!reset) begin
      stall_q = 1'b0;
    end else begin
      if (sti_rd) rd_cnt++;
      if (done) begin
        done_cnt++;
        chk("done_after_last_pixel", m_n, NPIX);
      end
      if (stall_q) begin
        chk("stall_valid", pix_valid, 1);
        chk("stall_idx", pix_idx, hold_idx);
        chk("stall_bit", pix_bit, hold_bit);
        chk("stall_last", pix_last, hold_last);
      end
      if (pix_valid) begin
        int e_idx;
        e_idx = m_dir ? (NPIX - 1 - m_n) : m_n;
        chk("model_idx", pix_idx, e_idx);
        chk("model_bit", pix_bit, img_bit(e_idx));
        chk("model_last", pix_last, (m_n == NPIX - 1));
        if (pix_ready) begin
          if (!m_dir && m_n < 16) first16[15 - m_n] = pix_bit;
          m_n++;
        end
      end
      stall_q   = pix_valid && !pix_ready;
      hold_idx  = m_dir ? (NPIX - 1 - m_n) : m_n;
      hold_bit  = img_bit(hold_idx);
      hold_last = (m_n == NPIX - 1);
    end
  end

  // Compare process for the small instance (forward scan only).
  always @(negedge clk) begin
    if (reset) begin
      if (s_rd) s_rd_cnt++;
      if (s_valid) begin
        chk("s_model_idx", s_idx, s_n);
        chk("s_model_bit", s_bit, s_img_bit(s_n));
        chk("s_model_last", s_last, (s_n == S_NPIX - 1));
        if (s_last) begin
          s_last_idx = s_idx;
          s_last_cnt++;
        end
        s_n++;
      end
    end
  end

  task automatic do_start(input logic d);
    @(posedge clk); #1;
    m_dir = d; m_n = 0;
    start = 1'b1; dir = d;
    @(posedge clk); #1;
    start = 1'b0; dir = 1'b0;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < NWORDS; i++) rom[i] = 16'($urandom);
    for (int i = 0; i < 32; i++) srom[i] = 8'($urandom);
    rom[0] = 16'h8001;
    rom[NWORDS-1] = 16'h0001;

    // reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sti_rd", sti_rd, 0);
    chk("rst_sti_addr", sti_addr, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_bit", pix_bit, 0);
    chk("rst_pix_idx", pix_idx, 0);
    chk("rst_pix_last", pix_last, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // small parameter set, forward, continuous ready
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (s_done) begin found = 1; break; end
    end
    chk("s_done_seen", found, 1);
    chk("s_pixels", s_n, 256);
    chk("s_rd_pulses", s_rd_cnt, 32);
    chk("s_last_idx", s_last_idx, 255);
    chk("s_last_count", s_last_cnt, 1);

    // forward scan with backpressure and an ignored start
    rd_cnt = 0;
    do_start(1'b0);
    chk("fwd_fetch_rd", sti_rd, 1);
    chk("fwd_fetch_addr", sti_addr, 0);
    chk("fwd_busy", busy, 1);
    chk("fwd_valid_c1", pix_valid, 0);
    @(posedge clk); #1;
    chk("fwd_valid_c2", pix_valid, 0);
    chk("fwd_rd_c2", sti_rd, 0);
    @(posedge clk); #1;
    chk("fwd_first_valid", pix_valid, 1);
    chk("fwd_first_idx", pix_idx, 0);
    chk("fwd_first_bit", pix_bit, 1);

    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (pix_valid && pix_idx == 14'd7) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("bp_reach_idx7", found, 1);
    pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", pix_valid, 1);
      chk("bp_idx", pix_idx, 7);
      chk("bp_bit", pix_bit, 0);
    end
    pix_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_resume_idx", pix_idx, 8);

    repeat (40) @(posedge clk);
    #1 start = 1'b1; dir = 1'b1;
    @(posedge clk); #1 start = 1'b0; dir = 1'b0;
    chk("busy_start_still_busy", busy, 1);

    found = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (done) begin found = 1; break; end
    end
    chk("fwd_done_seen", found, 1);
    chk("fwd_done_busy", busy, 0);
    chk("fwd_rd_pulses", rd_cnt, NWORDS);
    chk("fwd_first_word", first16, 16'h8001);

    // backward scan
    rd_cnt = 0;
    do_start(1'b1);
    chk("bwd_fetch_rd", sti_rd, 1);
    chk("bwd_fetch_addr", sti_addr, 1023);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bwd_first_valid", pix_valid, 1);
    chk("bwd_first_idx", pix_idx, 16383);
    chk("bwd_first_bit", pix_bit, 1);
    found = 0;
    for (int i = 0; i < 20000; i++) begin
      if (pix_valid && pix_last) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("bwd_last_seen", found, 1);
    chk("bwd_last_idx", pix_idx, 0);
    @(posedge clk); #1;
    chk("bwd_done", done, 1);
    chk("bwd_done_busy", busy, 0);
    @(posedge clk); #1;
    chk("bwd_done_one_cycle", done, 0);
    chk("bwd_rd_pulses", rd_cnt, NWORDS);

    // reset mid-scan
    do_start(1'b0);
    found = 0;
    for (int i = 0; i < 8000; i++) begin
      if (pix_valid && pix_idx == 14'd5000) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("rst_reach_5000", found, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sti_rd", sti_rd, 0);
    chk("abort_sti_addr", sti_addr, 0);
    chk("abort_pix_valid", pix_valid, 0);
    chk("abort_pix_bit", pix_bit, 0);
    chk("abort_pix_idx", pix_idx, 0);
    chk("abort_pix_last", pix_last, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done, 0);
    reset = 1'b1;
    do_start(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("restart_valid", pix_valid, 1);
    chk("restart_idx", pix_idx, 0);
    chk("restart_bit", pix_bit, 1);
    chk("done_pulse_count", done_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
